// File: rtl/key_action_scheduler.sv
// rtl/key_action_scheduler.sv - turns held key levels, auto-repeat and gravity into a one-at-a-time action stream
module key_action_scheduler #(
  parameter int DAS_FRAMES  = 16,
  parameter int ARR_FRAMES  = 6,
  parameter int SOFT_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       game_active,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_rotate,
  input  logic       key_down,
  input  logic       key_drop,
  input  logic [7:0] grav_period,
  output logic       act_valid,
  output logic [2:0] act_code,
  input  logic       act_ready
);

  localparam logic [7:0] DAS_M1  = 8'(DAS_FRAMES - 1);
  localparam logic [7:0] ARR_M1  = 8'(ARR_FRAMES - 1);
  localparam logic [7:0] SOFT_M1 = 8'(SOFT_FRAMES - 1);

  localparam int B_LEFT   = 0;
  localparam int B_RIGHT  = 1;
  localparam int B_ROTATE = 2;
  localparam int B_DOWN   = 3;
  localparam int B_DROP   = 4;

  localparam logic [2:0] C_LEFT   = 3'd1;
  localparam logic [2:0] C_RIGHT  = 3'd2;
  localparam logic [2:0] C_ROTATE = 3'd3;
  localparam logic [2:0] C_DOWN   = 3'd4;
  localparam logic [2:0] C_DROP   = 3'd5;

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  state_t     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic [4:0] keys, prev_q, edges, pend_q, pend_d, sets, clr;
  logic [7:0] lcnt_q, lcnt_d, rcnt_q, rcnt_d, gcnt_q, gcnt_d, grav_m1;
  logic       larr_q, larr_d, rarr_q, rarr_d;
  logic       l_fire, r_fire, g_fire, grant, drop_grant;

  assign keys       = {key_drop, key_down, key_rotate, key_right, key_left};
  assign edges      = keys & ~prev_q;
  assign grant      = (state_q == S_OFFER) && act_ready;
  assign drop_grant = grant && (code_q == C_DROP);

  // Each repeat counter first runs the DAS delay, then free-runs at the ARR rate.
  always_comb begin
    lcnt_d = lcnt_q;
    larr_d = larr_q;
    l_fire = 1'b0;
    if (!key_left) begin
      lcnt_d = 8'd0;
      larr_d = 1'b0;
    end else if (frame_tick && !key_right) begin
      if (lcnt_q == (larr_q ? ARR_M1 : DAS_M1)) begin
        l_fire = 1'b1;
        lcnt_d = 8'd0;
        larr_d = 1'b1;
      end else begin
        lcnt_d = lcnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    rcnt_d = rcnt_q;
    rarr_d = rarr_q;
    r_fire = 1'b0;
    if (!key_right) begin
      rcnt_d = 8'd0;
      rarr_d = 1'b0;
    end else if (frame_tick && !key_left) begin
      if (rcnt_q == (rarr_q ? ARR_M1 : DAS_M1)) begin
        r_fire = 1'b1;
        rcnt_d = 8'd0;
        rarr_d = 1'b1;
      end else begin
        rcnt_d = rcnt_q + 8'd1;
      end
    end
  end

  // >= rather than == so a shortened period (soft drop pressed) wraps at once.
  always_comb begin
    grav_m1 = key_down ? SOFT_M1 : ((grav_period == 8'd0) ? 8'd0 : grav_period - 8'd1);
    gcnt_d  = gcnt_q;
    g_fire  = 1'b0;
    if (frame_tick) begin
      if (gcnt_q >= grav_m1) begin
        g_fire = 1'b1;
        gcnt_d = 8'd0;
      end else begin
        gcnt_d = gcnt_q + 8'd1;
      end
    end
    if (edges[B_DOWN] || drop_grant) gcnt_d = 8'd0;
  end

  always_comb begin
    clr = 5'd0;
    if (grant) begin
      case (code_q)
        C_LEFT:   clr[B_LEFT]   = 1'b1;
        C_RIGHT:  clr[B_RIGHT]  = 1'b1;
        C_ROTATE: clr[B_ROTATE] = 1'b1;
        C_DOWN:   clr[B_DOWN]   = 1'b1;
        C_DROP: begin
          clr[B_DROP] = 1'b1;
          clr[B_DOWN] = 1'b1;
        end
        default: clr = 5'd0;
      endcase
    end
    sets         = edges;
    sets[B_LEFT] = edges[B_LEFT] | l_fire;
    sets[B_RIGHT]= edges[B_RIGHT] | r_fire;
    sets[B_DOWN] = edges[B_DOWN] | g_fire;
    // Set after clear: an event landing on the grant cycle survives.
    pend_d = (pend_q & ~clr) | sets;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          state_d = S_OFFER;
          if (pend_q[B_DROP])        code_d = C_DROP;
          else if (pend_q[B_ROTATE]) code_d = C_ROTATE;
          else if (pend_q[B_LEFT])   code_d = C_LEFT;
          else if (pend_q[B_RIGHT])  code_d = C_RIGHT;
          else                       code_d = C_DOWN;
        end
      end
      S_OFFER: begin
        if (act_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!game_active) begin
      state_d = S_IDLE;
      code_d  = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      code_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 5'd0;
      pend_q <= 5'd0;
      lcnt_q <= 8'd0;
      rcnt_q <= 8'd0;
      gcnt_q <= 8'd0;
      larr_q <= 1'b0;
      rarr_q <= 1'b0;
    end else if (!game_active) begin
      // Track current levels so keys held while paused do not fire on resume.
      prev_q <= keys;
      pend_q <= 5'd0;
      lcnt_q <= 8'd0;
      rcnt_q <= 8'd0;
      gcnt_q <= 8'd0;
      larr_q <= 1'b0;
      rarr_q <= 1'b0;
    end else begin
      prev_q <= keys;
      pend_q <= pend_d;
      lcnt_q <= lcnt_d;
      rcnt_q <= rcnt_d;
      gcnt_q <= gcnt_d;
      larr_q <= larr_d;
      rarr_q <= rarr_d;
    end
  end

  assign act_valid = (state_q == S_OFFER);
  assign act_code  = act_valid ? code_q : 3'd0;

endmodule

// File: tb/tb_key_action_scheduler.sv
// tb/tb_key_action_scheduler.sv - randomized and directed bench for key_action_scheduler against a frame-level model
module tb_key_action_scheduler;

  localparam int DAS  = 16;
  localparam int ARR  = 6;
  localparam int SOFT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick, game_active;
  logic       key_left, key_right, key_rotate, key_down, key_drop;
  logic [7:0] grav_period;
  logic       act_valid;
  logic [2:0] act_code;
  logic       act_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: pending/prev indexed by action code 1..5.
  bit [5:0] m_pend, m_prev;
  int       m_nl, m_nr, m_g, m_code;
  bit       m_offer;

  key_action_scheduler dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .game_active(game_active),
    .key_left(key_left), .key_right(key_right), .key_rotate(key_rotate),
    .key_down(key_down), .key_drop(key_drop), .grav_period(grav_period),
    .act_valid(act_valid), .act_code(act_code), .act_ready(act_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit rep_fire(input int n);
    return (n == DAS) || (n > DAS && ((n - DAS) % ARR) == 0);
  endfunction

  function automatic int prio(input bit [5:0] p);
    if (p[5]) return 5;
    if (p[3]) return 3;
    if (p[1]) return 1;
    if (p[2]) return 2;
    return 4;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_prev = '0; m_nl = 0; m_nr = 0; m_g = 0; m_code = 0; m_offer = 0;
  endtask

  task automatic model_step();
    bit [5:0] k, set, clr;
    int p;
    k = {key_drop, key_down, key_rotate, key_right, key_left, 1'b0};
    if (!game_active) begin
      model_reset();
      m_prev = k;
      return;
    end
    set = k & ~m_prev;
    clr = '0;
    if (!key_left) m_nl = 0;
    else if (frame_tick && !key_right) begin
      m_nl++;
      if (rep_fire(m_nl)) set[1] = 1;
    end
    if (!key_right) m_nr = 0;
    else if (frame_tick && !key_left) begin
      m_nr++;
      if (rep_fire(m_nr)) set[2] = 1;
    end
    p = key_down ? SOFT : ((grav_period == 0) ? 1 : int'(grav_period));
    if (frame_tick && m_g + 1 >= p) set[4] = 1;
    if (key_down && !m_prev[4]) m_g = 0;
    else if (frame_tick) m_g = (m_g + 1 >= p) ? 0 : m_g + 1;
    if (m_offer && act_ready) begin
      clr[m_code] = 1;
      if (m_code == 5) begin
        clr[4] = 1;
        m_g = 0;
      end
      m_offer = 0;
    end else if (!m_offer && m_pend != 0) begin
      m_offer = 1;
      m_code  = prio(m_pend);
    end
    m_pend = (m_pend & ~clr) | set;
    m_prev = k;
  endtask

  // Inputs are set at a negedge; this advances one clock and checks at the next negedge.
  task automatic tick_cycle();
    if (!rst_n) model_reset(); else model_step();
    @(posedge clk);
    @(negedge clk);
    check("act_valid", int'(act_valid), int'(m_offer));
    check("act_code", int'(act_code), m_offer ? m_code : 0);
  endtask

  task automatic random_cycle(input int ready_pct);
    key_left    ^= ($urandom_range(39) == 0);
    key_right   ^= ($urandom_range(39) == 0);
    key_rotate  ^= ($urandom_range(9) == 0);
    key_down    ^= ($urandom_range(14) == 0);
    key_drop    ^= ($urandom_range(19) == 0);
    frame_tick  = ($urandom_range(2) == 0);
    act_ready   = ($urandom_range(99) < ready_pct);
    game_active = ($urandom_range(299) != 0);
    tick_cycle();
  endtask

  task automatic clear_state();
    {key_left, key_right, key_rotate, key_down, key_drop} = '0;
    frame_tick = 0; act_ready = 1; game_active = 0;
    tick_cycle();
    game_active = 1;
  endtask

  task automatic run_frames(input int nframes, input int tick_at, input int code, output int cnt);
    cnt = 0;
    for (int f = 0; f < nframes + 2; f++) begin
      for (int c = 0; c < 4; c++) begin
        frame_tick = (c == tick_at) && (f < nframes);
        tick_cycle();
        if (act_valid && act_code == 3'(code)) cnt++;
      end
    end
  endtask

  initial begin
    int cnt, nv;
    int codes[4], idx[4];
    rst_n = 0; game_active = 1; frame_tick = 0; act_ready = 1; grav_period = 8'd255;
    {key_left, key_right, key_rotate, key_down, key_drop} = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_valid", int'(act_valid), 0);
    check("rst_code", int'(act_code), 0);
    rst_n = 1;

    // Rotate press reaches the output two clocks later, for one cycle.
    clear_state();
    key_rotate = 1;
    cnt = 0;
    while (!act_valid && cnt < 10) begin
      tick_cycle();
      cnt++;
    end
    check("rotate_latency", cnt, 2);
    check("rotate_code", int'(act_code), 3);
    tick_cycle();
    check("rotate_len", int'(act_valid), 0);

    // Left held 30 frames: actions at frames 0, 16, 22, 28.
    clear_state();
    key_left = 1;
    run_frames(30, 3, 1, cnt);
    check("left_repeats", cnt, 4);

    // Simultaneous drop and left: drop first, one idle cycle, then left.
    clear_state();
    key_drop = 1; key_left = 1;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      tick_cycle();
      if (act_valid && nv < 4) begin
        codes[nv] = int'(act_code);
        idx[nv] = i;
        nv++;
      end
    end
    check("drop_left_count", nv, 2);
    check("drop_first", codes[0], 5);
    check("left_second", codes[1], 1);
    check("drop_left_gap", idx[1] - idx[0], 2);

    // Gravity period 0 behaves as 1; soft drop gives one every 2 frames plus the press.
    clear_state();
    grav_period = 8'd0;
    run_frames(10, 0, 4, cnt);
    check("grav_every_frame", cnt, 10);
    clear_state();
    grav_period = 8'd48;
    key_down = 1;
    run_frames(10, 2, 4, cnt);
    check("soft_drop_count", cnt, 6);

    // Stalled offer holds while other events accumulate.
    clear_state();
    key_left = 1; act_ready = 0;
    tick_cycle(); tick_cycle();
    check("stall_offer_code", int'(act_code), 1);
    for (int i = 0; i < 100; i++) begin
      key_rotate ^= ($urandom_range(4) == 0);
      key_drop   ^= ($urandom_range(6) == 0);
      frame_tick = ($urandom_range(3) == 0);
      tick_cycle();
    end
    check("stall_hold_code", int'(act_code), 1);

    // game_active dropped mid-offer.
    game_active = 0;
    tick_cycle();
    check("pause_valid", int'(act_valid), 0);
    game_active = 1;

    // Async reset mid-offer.
    clear_state();
    key_rotate = 1; act_ready = 0;
    tick_cycle(); tick_cycle();
    check("pre_reset_valid", int'(act_valid), 1);
    rst_n = 0;
    #1;
    check("async_rst_valid", int'(act_valid), 0);
    check("async_rst_code", int'(act_code), 0);
    model_reset();
    tick_cycle(); tick_cycle();
    rst_n = 1;

    for (int seg = 0; seg < 16; seg++) begin
      case (seg % 4)
        0: grav_period = 8'd0;
        1: grav_period = 8'd1;
        2: grav_period = 8'd3;
        default: grav_period = 8'd48;
      endcase
      for (int i = 0; i < 1500; i++) random_cycle((seg % 3 == 0) ? 30 : 80);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_action_scheduler.md
KEY_ACTION_SCHEDULER -- requirements
Module: key_action_scheduler

Interface
REQ-001 Parameter DAS_FRAMES, default 16, frames a left/right key must stay held before auto-repeat starts.
REQ-002 Parameter ARR_FRAMES, default 6, frames between auto-repeat actions after DAS expires.
REQ-003 Parameter SOFT_FRAMES, default 2, gravity period in frames while key_down is held.
REQ-004 clk  input  1  system clock (VGA pixel clock domain).
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 frame_tick  input  1  one-cycle pulse per frame (end of 800x525 scan).
REQ-007 game_active  input  1  level; 0 freezes and clears the scheduler.
REQ-008 key_left, key_right, key_rotate, key_down, key_drop  input  1 each  stabilized held levels.
REQ-009 grav_period  input  8  gravity period in frames; value 0 treated as 1.
REQ-010 act_valid  output  1  action offered to game logic.
REQ-011 act_code  output  3  1=left 2=right 3=rotate 4=down 5=hard drop; 0 when idle.
REQ-012 act_ready  input  1  game logic accepts the offered action this cycle.

Function
REQ-013 Rising edge of any key level (registered previous level vs current) SHALL set that key's pending bit on the next clock.
REQ-014 Left auto-repeat: while key_left held alone, count frame_ticks; at DAS_FRAMES ticks set pending-left, then every ARR_FRAMES ticks thereafter; release clears the counter.
REQ-015 Right auto-repeat SHALL mirror REQ-014; if left and right are both held, neither repeat counter advances (edges still register).
REQ-016 Rotate and hard drop SHALL NOT auto-repeat.
REQ-017 Gravity counter SHALL increment on frame_tick; on reaching period-1 it sets pending-down and wraps to 0; period = SOFT_FRAMES while key_down held, else max(grav_period,1).
REQ-018 Rising edge of key_down SHALL set pending-down and reset the gravity counter to 0.
REQ-019 Arbiter: two states IDLE and OFFER; in IDLE with any pending bit, go OFFER next cycle with fixed priority drop > rotate > left > right > down.
REQ-020 In OFFER, act_valid=1 and act_code SHALL stay stable until act_ready=1; on that cycle the granted pending bit clears and state returns to IDLE.
REQ-021 Throughput: at most one action per two clocks; act_valid SHALL deassert for at least one cycle between actions.
REQ-022 A new event for the bit being granted in the same cycle SHALL leave that bit set (set wins over clear).
REQ-023 Multiple events for an already-pending bit SHALL coalesce into one action.
REQ-024 Hard-drop grant SHALL clear pending-down and reset the gravity counter.
REQ-025 game_active=0 SHALL synchronously clear all pending bits, counters and edge registers to current levels, force IDLE and act_valid=0, even mid-OFFER.
REQ-026 Counters SHALL be 8-bit; no overflow since each wraps at its period.

Reset
REQ-027 rst_n=0 SHALL asynchronously force act_valid=0, act_code=0, state IDLE, all pending bits, counters and previous-level registers to 0.
REQ-028 After rst_n release, a key already held SHALL register as a rising edge on the first clock.

Verification
REQ-029 key_rotate 0->1, act_ready=1 -> act_valid=1, act_code=3 exactly two cycles after edge, one cycle long.
REQ-030 key_left held 30 frames, act_ready=1 -> left actions at frame 0, 16, 22, 28 (4 total).
REQ-031 key_drop and key_left rise same cycle, act_ready=1 -> code 5 then code 2... no: code 5 then code 1, separated by one idle cycle.
REQ-032 grav_period=0 -> one down action every frame; grav_period=48, key_down held -> down every 2 frames.
REQ-033 act_ready=0 for 100 cycles during OFFER code 1 -> act_valid and act_code=1 stable throughout; other events remain pending.
REQ-034 game_active dropped mid-OFFER, or rst_n pulsed low -> act_valid=0 next edge (async for rst_n), no stale action afterwards.
